id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection.

---
 rtl/id_ex_stage_pkg.sv | 35 +++
 rtl/id_ex_stage_fwd_mux.sv | 39 +++
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU operation codes, the EX control
// bundle with its bubble value, and forwarding source selects.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE = '{regwrite: 1'b0, memread: 1'b0,
                                  memwrite: 1'b0, memtoreg: 1'b0};

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks the freshest value of one source register from
// EX/MEM, then MEM/WB, then the register-file copy. Register 0 never forwards.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] src,
  input  logic [DW-1:0]  rdata,
  input  logic           exmem_regwrite,
  input  logic [RAW-1:0] exmem_waddr,
  input  logic [DW-1:0]  exmem_result,
  input  logic           memwb_regwrite,
  input  logic [RAW-1:0] memwb_waddr,
  input  logic [DW-1:0]  memwb_wdata,
  output logic [DW-1:0]  data
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (exmem_regwrite && (exmem_waddr != '0) && (exmem_waddr == src))
      sel = FWD_EXMEM;
    else if (memwb_regwrite && (memwb_waddr != '0) && (memwb_waddr == src))
      sel = FWD_MEMWB;
  end

  always_comb begin
    data = rdata;
    case (sel)
      FWD_EXMEM: data = exmem_result;
      FWD_MEMWB: data = memwb_wdata;
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard
// detection; drives the final ALU operands and the IF/ID stall.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int          DW     = 32,
  parameter int          RAW    = 5,
  parameter logic [DW-1:0] PC_RST = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [DW-1:0]  id_pc,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic [RAW-1:0] id_waddr,
  input  logic [DW-1:0]  id_rdata1,
  input  logic [DW-1:0]  id_rdata2,
  input  logic [DW-1:0]  id_imm,
  input  logic [4:0]     id_shamt,
  input  logic           id_shamt_var,
  input  logic [3:0]     id_aluop,
  input  logic           id_alusrc,
  input  logic           id_regwrite,
  input  logic           id_memread,
  input  logic           id_memwrite,
  input  logic           id_memtoreg,
  input  logic           exmem_regwrite,
  input  logic [RAW-1:0] exmem_waddr,
  input  logic [DW-1:0]  exmem_result,
  input  logic           memwb_regwrite,
  input  logic [RAW-1:0] memwb_waddr,
  input  logic [DW-1:0]  memwb_wdata,
  input  logic           ex_hold,
  input  logic           ex_flush,
  output logic           stall_ifid,
  output logic           ex_valid,
  output logic [DW-1:0]  ex_pc,
  output logic [DW-1:0]  ex_A,
  output logic [DW-1:0]  ex_B,
  output logic [4:0]     ex_shamt,
  output logic [3:0]     ex_aluop,
  output logic [DW-1:0]  ex_store_data,
  output logic [RAW-1:0] ex_waddr,
  output logic           ex_regwrite,
  output logic           ex_memread,
  output logic           ex_memwrite,
  output logic           ex_memtoreg
);

  logic           vld_p1;
  logic [DW-1:0]  pc_p1;
  logic [RAW-1:0] rs_p1;
  logic [RAW-1:0] rt_p1;
  logic [RAW-1:0] waddr_p1;
  logic [DW-1:0]  rdata1_p1;
  logic [DW-1:0]  rdata2_p1;
  logic [DW-1:0]  imm_p1;
  logic [4:0]     shamt_p1;
  logic           shamt_var_p1;
  logic [3:0]     aluop_p1;
  logic           alusrc_p1;
  ex_ctrl_t       ctrl_p1;

  ex_ctrl_t       id_ctrl;
  logic           hazard;
  logic           bubble;
  logic [DW-1:0]  fwd_rs;
  logic [DW-1:0]  fwd_rt;

  assign id_ctrl = '{regwrite: id_regwrite, memread: id_memread,
                     memwrite: id_memwrite, memtoreg: id_memtoreg};

  // A store reads rt as data even with an immediate B, so it still hazards on rt.
  assign hazard = vld_p1 && ctrl_p1.memread && (waddr_p1 != '0) && id_valid &&
                  ((waddr_p1 == id_rs) ||
                   ((waddr_p1 == id_rt) && (!id_alusrc || id_memwrite)));

  assign stall_ifid = (hazard || ex_hold) && !ex_flush && !rst;
  assign bubble     = ex_flush || hazard || !id_valid;

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      pc_p1        <= PC_RST;
      rs_p1        <= '0;
      rt_p1        <= '0;
      waddr_p1     <= '0;
      rdata1_p1    <= '0;
      rdata2_p1    <= '0;
      imm_p1       <= '0;
      shamt_p1     <= '0;
      shamt_var_p1 <= 1'b0;
      aluop_p1     <= ALU_NOP;
      alusrc_p1    <= 1'b0;
      ctrl_p1      <= BUBBLE;
    end else if (!ex_hold) begin
      pc_p1        <= id_pc;
      rs_p1        <= id_rs;
      rt_p1        <= id_rt;
      rdata1_p1    <= id_rdata1;
      rdata2_p1    <= id_rdata2;
      imm_p1       <= id_imm;
      shamt_p1     <= id_shamt;
      shamt_var_p1 <= id_shamt_var;
      alusrc_p1    <= id_alusrc;
      if (bubble) begin
        vld_p1   <= 1'b0;
        waddr_p1 <= '0;
        aluop_p1 <= ALU_NOP;
        ctrl_p1  <= BUBBLE;
      end else begin
        vld_p1   <= 1'b1;
        waddr_p1 <= id_waddr;
        aluop_p1 <= id_aluop;
        ctrl_p1  <= id_ctrl;
      end
    end
  end

  fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_rs (
    .src            (rs_p1),
    .rdata          (rdata1_p1),
    .exmem_regwrite (exmem_regwrite),
    .exmem_waddr    (exmem_waddr),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_waddr    (memwb_waddr),
    .memwb_wdata    (memwb_wdata),
    .data           (fwd_rs)
  );

  fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_rt (
    .src            (rt_p1),
    .rdata          (rdata2_p1),
    .exmem_regwrite (exmem_regwrite),
    .exmem_waddr    (exmem_waddr),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_waddr    (memwb_waddr),
    .memwb_wdata    (memwb_wdata),
    .data           (fwd_rt)
  );

  assign ex_valid      = vld_p1;
  assign ex_pc         = pc_p1;
  assign ex_A          = fwd_rs;
  assign ex_store_data = fwd_rt;
  assign ex_B          = alusrc_p1 ? imm_p1 : fwd_rt;
  assign ex_shamt      = shamt_var_p1 ? fwd_rs[4:0] : shamt_p1;
  assign ex_aluop      = aluop_p1;
  assign ex_waddr      = waddr_p1;
  assign ex_regwrite   = ctrl_p1.regwrite;
  assign ex_memread    = ctrl_p1.memread;
  assign ex_memwrite   = ctrl_p1.memwrite;
  assign ex_memtoreg   = ctrl_p1.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expectations are queued as stimulus is
// applied and drained against the DUT outputs away from the clock edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW  = 32;
  localparam int RAW = 5;

  localparam int S_VALID = 0, S_PC = 1, S_A = 2, S_B = 3, S_SHAMT = 4,
                 S_ALUOP = 5, S_STORE = 6, S_WADDR = 7, S_CTRL = 8, S_STALL = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid;
  logic [DW-1:0]  id_pc;
  logic [RAW-1:0] id_rs, id_rt, id_waddr;
  logic [DW-1:0]  id_rdata1, id_rdata2, id_imm;
  logic [4:0]     id_shamt;
  logic           id_shamt_var;
  logic [3:0]     id_aluop;
  logic           id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic           exmem_regwrite;
  logic [RAW-1:0] exmem_waddr;
  logic [DW-1:0]  exmem_result;
  logic           memwb_regwrite;
  logic [RAW-1:0] memwb_waddr;
  logic [DW-1:0]  memwb_wdata;
  logic           ex_hold, ex_flush;
  logic           stall_ifid, ex_valid;
  logic [DW-1:0]  ex_pc, ex_A, ex_B, ex_store_data;
  logic [4:0]     ex_shamt;
  logic [3:0]     ex_aluop;
  logic [RAW-1:0] ex_waddr;
  logic           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  id_ex_stage #(.DW(DW), .RAW(RAW), .PC_RST('0)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_waddr(id_waddr),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_shamt_var(id_shamt_var), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_waddr(exmem_waddr),
    .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
    .memwb_waddr(memwb_waddr), .memwb_wdata(memwb_wdata),
    .ex_hold(ex_hold), .ex_flush(ex_flush), .stall_ifid(stall_ifid),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_A(ex_A), .ex_B(ex_B),
    .ex_shamt(ex_shamt), .ex_aluop(ex_aluop), .ex_store_data(ex_store_data),
    .ex_waddr(ex_waddr), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_VALID: return {31'd0, ex_valid};
      S_PC:    return ex_pc;
      S_A:     return ex_A;
      S_B:     return ex_B;
      S_SHAMT: return {27'd0, ex_shamt};
      S_ALUOP: return {28'd0, ex_aluop};
      S_STORE: return ex_store_data;
      S_WADDR: return {27'd0, ex_waddr};
      S_CTRL:  return {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg};
      default: return {31'd0, stall_ifid};
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] wa, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] sh,
                        input logic svar, input logic [3:0] op, input logic asrc,
                        input logic [3:0] ctl);
    id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_waddr = wa;
    id_rdata1 = rd1; id_rdata2 = rd2; id_imm = imm; id_shamt = sh;
    id_shamt_var = svar; id_aluop = op; id_alusrc = asrc;
    {id_regwrite, id_memread, id_memwrite, id_memtoreg} = ctl;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                         input logic mw, input logic [4:0] ma, input logic [31:0] md);
    exmem_regwrite = ew; exmem_waddr = ea; exmem_result = ed;
    memwb_regwrite = mw; memwb_waddr = ma; memwb_wdata = md;
  endtask

  task automatic load_lw_r4(input logic [31:0] pc);
    set_id(1'b1, pc, 5'd1, 5'd0, 5'd4, 32'h10, 32'h0, 32'h8, 5'd0, 1'b0, ALU_ADD, 1'b1, 4'b1101);
    tick();
    push("lw_valid", S_VALID, 32'd1);
    push("lw_ctrl", S_CTRL, 32'hD);
    push("lw_b_imm", S_B, 32'h8);
    drain();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ex_hold = 1'b0; ex_flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, 32'h44, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 5'd0, 1'b0, ALU_ADD, 1'b0, 4'b1000);
    tick(); tick();
    push("rst_valid", S_VALID, 32'd0);
    push("rst_aluop", S_ALUOP, {28'd0, ALU_NOP});
    push("rst_pc", S_PC, 32'h0);
    push("rst_stall", S_STALL, 32'd0);
    push("rst_ctrl", S_CTRL, 32'h0);
    drain();

    // ADD r3,r1,r2 with rdata 5,7
    rst = 1'b0;
    set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 5'd5, 1'b0, ALU_ADD, 1'b0, 4'b1000);
    tick();
    push("add_valid", S_VALID, 32'd1);
    push("add_pc", S_PC, 32'h40);
    push("add_waddr", S_WADDR, 32'd3);
    push("add_ctrl", S_CTRL, 32'h8);
    push("add_aluop", S_ALUOP, {28'd0, ALU_ADD});
    push("add_a_reg", S_A, 32'h5);
    push("add_b_reg", S_B, 32'h7);
    push("add_shamt", S_SHAMT, 32'd5);
    drain();
    set_fwd(1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 32'h0);
    push("fwd_exmem_a", S_A, 32'h100);
    push("fwd_exmem_b", S_B, 32'h7);
    settle();
    set_fwd(1'b1, 5'd2, 32'hAA, 1'b1, 5'd2, 32'hBB);
    push("fwd_prio_b", S_B, 32'hAA);
    push("fwd_prio_st", S_STORE, 32'hAA);
    push("fwd_prio_a", S_A, 32'h5);
    settle();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'hCC);
    push("fwd_memwb_a", S_A, 32'hCC);
    settle();

    // ADD r3,r1,r0: writers to register 0 must not forward
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, 32'h48, 5'd1, 5'd0, 5'd3, 32'h5, 32'h77, 32'h0, 5'd0, 1'b0, ALU_ADD, 1'b0, 4'b1000);
    tick();
    set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    push("fwd_r0_b", S_B, 32'h77);
    push("fwd_r0_st", S_STORE, 32'h77);
    settle();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Load-use: LW r4 then ADD r5,r4,r1
    load_lw_r4(32'h50);
    set_id(1'b1, 32'h54, 5'd4, 5'd1, 5'd5, 32'h0, 32'h1, 32'h0, 5'd0, 1'b0, ALU_ADD, 1'b0, 4'b1000);
    push("lu_stall", S_STALL, 32'd1);
    settle();
    tick();
    push("lu_bubble_valid", S_VALID, 32'd0);
    push("lu_bubble_ctrl", S_CTRL, 32'h0);
    push("lu_bubble_waddr", S_WADDR, 32'd0);
    push("lu_bubble_aluop", S_ALUOP, {28'd0, ALU_NOP});
    push("lu_stall_clear", S_STALL, 32'd0);
    drain();
    tick();
    push("lu_capt_valid", S_VALID, 32'd1);
    push("lu_capt_pc", S_PC, 32'h54);
    push("lu_capt_waddr", S_WADDR, 32'd5);
    drain();

    // Load-use with flush: no stall, bubble next
    load_lw_r4(32'h60);
    set_id(1'b1, 32'h64, 5'd4, 5'd1, 5'd5, 32'h0, 32'h1, 32'h0, 5'd0, 1'b0, ALU_ADD, 1'b0, 4'b1000);
    ex_flush = 1'b1;
    push("flush_stall", S_STALL, 32'd0);
    settle();
    tick();
    push("flush_valid", S_VALID, 32'd0);
    push("flush_ctrl", S_CTRL, 32'h0);
    drain();
    ex_flush = 1'b0;

    // SLLV r8,r7,r6 then hold for three cycles
    set_id(1'b1, 32'h80, 5'd6, 5'd7, 5'd8, 32'h3, 32'h9, 32'h0, 5'd2, 1'b1, ALU_SLL, 1'b0, 4'b1000);
    tick();
    set_fwd(1'b1, 5'd6, 32'h1F, 1'b0, 5'd0, 32'h0);
    push("sllv_shamt", S_SHAMT, 32'h1F);
    settle();
    ex_hold = 1'b1;
    set_id(1'b1, 32'h99, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, ALU_SUB, 1'b0, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      push("hold_stall", S_STALL, 32'd1);
      settle();
      tick();
      push("hold_pc", S_PC, 32'h80);
      push("hold_waddr", S_WADDR, 32'd8);
      push("hold_aluop", S_ALUOP, {28'd0, ALU_SLL});
      push("hold_valid", S_VALID, 32'd1);
      drain();
    end
    exmem_result = 32'h2A;
    push("hold_live_a", S_A, 32'h2A);
    push("hold_live_shamt", S_SHAMT, 32'h0A);
    settle();
    ex_flush = 1'b1;
    push("hold_flush_stall", S_STALL, 32'd0);
    settle();
    tick();
    push("hold_over_flush_pc", S_PC, 32'h80);
    push("hold_over_flush_valid", S_VALID, 32'd1);
    drain();
    ex_hold = 1'b0; ex_flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset asserted while a load-use stall is pending
    load_lw_r4(32'hA0);
    set_id(1'b1, 32'hA4, 5'd4, 5'd1, 5'd5, 32'h0, 32'h1, 32'h0, 5'd0, 1'b0, ALU_ADD, 1'b0, 4'b1000);
    push("rs_stall_before", S_STALL, 32'd1);
    settle();
    rst = 1'b1;
    push("rs_stall_during", S_STALL, 32'd0);
    settle();
    tick();
    rst = 1'b0;
    push("rs_valid", S_VALID, 32'd0);
    push("rs_pc", S_PC, 32'h0);
    push("rs_stall_after", S_STALL, 32'd0);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
